cdc_2phase_mux_dst: RTL

- Multi-channel destination half of a two-phase CDC, built as a parametrised successor to the single-channel receiver.
- Accepts N_CH independent two-phase req/ack/data links, each driven by an existing two-phase source half in a foreign clock domain.
- Synchronises every req, arbitrates pending channels round-robin and buffers captured words in a DEPTH-entry FIFO.
- Presents one valid/ready stream tagged with the channel index.
- The FIFO lets acks return before the consumer drains, so a slow consumer does not throttle every link to the full round-trip rate.

---
 rtl/cdc_2phase_mux_dst_if.sv | 29 ++
 rtl/cdc_2phase_mux_dst_sync_ff_chain.sv | 24 ++
 rtl/cdc_2phase_mux_dst.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cdc_2phase_mux_dst_if.sv
// Link and stream bundle for the multi-channel two-phase CDC receiver.
// The slave side is the receiver. The master side is the sources plus the consumer.
interface cdc_2phase_mux_dst_if #(
    parameter int N_CH   = 4,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 4
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N_CH-1:0]        async_req_i;
    logic [N_CH-1:0]        async_ack_o;
    logic [N_CH*W_DATA-1:0] async_data_i;
    logic [W_DATA-1:0]      data_o;
    logic [CH_W-1:0]        ch_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [CNT_W-1:0]       level_o;

    modport slave (
        input  async_req_i, async_data_i, ready_i,
        output async_ack_o, data_o, ch_o, valid_o, level_o
    );

    modport master (
        output async_req_i, async_data_i, ready_i,
        input  async_ack_o, data_o, ch_o, valid_o, level_o
    );
endinterface

// File: rtl/cdc_2phase_mux_dst_sync_ff_chain.sv
// STAGES-deep async-reset synchroniser for one asynchronous level signal.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q, sync_d;

    // Shift the incoming level one flop deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchroniser flops clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_2phase_mux_dst.sv
// Multi-channel destination half of a two-phase CDC. Each req line is synchronised.
// Pending links are served round-robin. Captured words pass through a DEPTH-entry FIFO
// onto a single valid/ready stream that is tagged with the channel index.
module cdc_2phase_mux_dst #(
    parameter int N_CH        = 4,
    parameter int W_DATA      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cdc_2phase_mux_dst_if.slave  bus
);
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int CH_W  = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N_CH-1:0]   req_s, pend;
    logic [N_CH-1:0]   ack_q, ack_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [W_DATA-1:0] mem_data_q [DEPTH];
    logic [W_DATA-1:0] mem_data_d [DEPTH];
    logic [CH_W-1:0]   mem_ch_q   [DEPTH];
    logic [CH_W-1:0]   mem_ch_d   [DEPTH];
    logic              gnt_vld, push, pop, full;
    logic [CH_W-1:0]   gnt_idx;

    for (genvar c = 0; c < N_CH; c++) begin : g_sync
        sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (bus.async_req_i[c]),
            .q_o    (req_s[c])
        );
    end

    // A link is pending while its synchronised req differs from the ack we hold locally.
    assign pend = req_s ^ ack_q;
    assign full = (level_q == CNT_W'(DEPTH));

    // Round-robin search that starts one past the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!gnt_vld && pend[(int'(last_q) + i) % N_CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'((int'(last_q) + i) % N_CH);
            end
        end
    end

    // A pop on a full cycle does not free a slot for the same edge.
    assign push = gnt_vld && !full;
    assign pop  = (level_q != '0) && bus.ready_i;

    // Next state of the acks, the arbiter pointer and the FIFO.
    always_comb begin
        ack_d      = ack_q;
        last_d     = last_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        level_d    = level_q;
        mem_data_d = mem_data_q;
        mem_ch_d   = mem_ch_q;
        if (push) begin
            ack_d[gnt_idx]   = ~ack_q[gnt_idx];
            last_d           = gnt_idx;
            mem_data_d[wr_q] = bus.async_data_i[int'(gnt_idx)*W_DATA +: W_DATA];
            mem_ch_d[wr_q]   = gnt_idx;
            wr_d             = wr_q + PTR_W'(1);
        end
        if (pop) rd_d = rd_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Reset clears the storage so that data_o and ch_o read as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q   <= '0;
            last_q  <= CH_W'(N_CH - 1);
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ch_q[i]   <= '0;
            end
        end else begin
            ack_q      <= ack_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            mem_data_q <= mem_data_d;
            mem_ch_q   <= mem_ch_d;
        end
    end

    assign bus.async_ack_o = ack_q;
    assign bus.data_o      = mem_data_q[rd_q];
    assign bus.valid_o     = (level_q != '0);
    assign bus.level_o     = level_q;

    if (N_CH == 1) begin : g_ch_tie
        assign bus.ch_o = '0;
    end else begin : g_ch_fifo
        assign bus.ch_o = mem_ch_q[rd_q];
    end
endmodule
